// File: rtl/osc_cnt_pkg.sv
// Shared types and constants for the ring-oscillator frequency counter.
// OSC_CNT_AVG_EN widens the gate counter to span four averaged windows.
package osc_cnt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    GATE,
    DONE
  } osc_state_t;

  localparam int CNT_W          = 16;
  localparam int ARM_CYCLES     = 2;
  localparam int GATE_BASE_LOG2 = 10;

`ifdef OSC_CNT_AVG_EN
  localparam int AVG_LOG2 = 2;
`else
  localparam int AVG_LOG2 = 0;
`endif

  // Longest window is 2^17 cycles; averaging runs four of them back to back.
  localparam int GATE_CNT_W = 17 + AVG_LOG2;

endpackage

// File: rtl/osc_freq_counter_sync_edge_det.sv
// Two-flop synchronizer on the asynchronous oscillator input plus a history
// flop; rise pulses for one clk on each synchronized rising edge.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic osc_in,
  output logic rise
);

  logic sync_p0;
  logic sync_p1;
  logic prev_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
    end else begin
      sync_p0 <= osc_in;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign rise = sync_p1 & ~prev_p2;

endmodule

// File: rtl/osc_freq_counter.sv
// Gated, saturating edge counter for a pre-divided ring oscillator, byte readout.
// Define OSC_CNT_AVG_EN to average four consecutive gate windows.
module osc_freq_counter
  import osc_cnt_pkg::*;
#(
  parameter int CNT_W      = osc_cnt_pkg::CNT_W,
  parameter int GATE_SEL_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  osc_in,
  input  logic                  start,
  input  logic [GATE_SEL_W-1:0] gate_sel,
  input  logic                  byte_sel,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [7:0]            read_data
);

  // MSB of the return value flags an increment attempted at full scale.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] c,
                                             input logic              inc);
    logic [CNT_W:0] r;
    if (!inc) begin
      r = {1'b0, c};
    end else if (&c) begin
      r = {1'b1, c};
    end else begin
      r = {1'b0, c + CNT_W'(1)};
    end
    return r;
  endfunction

  osc_state_t             state;
  logic                   rise;
  logic [GATE_SEL_W-1:0]  gsel_q;
  logic [GATE_CNT_W-1:0]  gate_cnt;
  logic [GATE_CNT_W-1:0]  meas_mask;
  logic                   meas_end;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_inc;
  logic                   ovf_bit;
  logic                   ovf_inc;
  logic [CNT_W-1:0]       result;
  logic [CNT_W-1:0]       result_nx;
  logic [15:0]            res16;
`ifdef OSC_CNT_AVG_EN
  logic [GATE_CNT_W-1:0]  win_mask;
  logic                   win_end;
  logic [CNT_W+1:0]       acc;
  logic [CNT_W+1:0]       acc_sum;
`endif

  sync_edge_det u_sync (
    .clk    (clk),
    .rst    (rst),
    .osc_in (osc_in),
    .rise   (rise)
  );

  // Window end is detected by the gate counter reaching an all-ones mask,
  // so no separate length register or comparator per gate_sel is needed.
  always_comb begin
    {ovf_inc, cnt_inc} = sat_inc(cnt, rise);
    meas_mask = (GATE_CNT_W'(1) << (GATE_BASE_LOG2 + AVG_LOG2 + int'(gsel_q)))
                - GATE_CNT_W'(1);
    meas_end  = (gate_cnt == meas_mask);
`ifdef OSC_CNT_AVG_EN
    win_mask  = (GATE_CNT_W'(1) << (GATE_BASE_LOG2 + int'(gsel_q))) - GATE_CNT_W'(1);
    win_end   = ((gate_cnt & win_mask) == win_mask);
    acc_sum   = acc + {2'b00, cnt_inc};
    result_nx = acc_sum[CNT_W+1:2];
`else
    result_nx = cnt_inc;
`endif
  end

  assign res16 = 16'(result);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      result    <= '0;
      read_data <= '0;
      cnt       <= '0;
      ovf_bit   <= 1'b0;
      gate_cnt  <= '0;
      gsel_q    <= '0;
`ifdef OSC_CNT_AVG_EN
      acc       <= '0;
`endif
    end else begin
      read_data <= byte_sel ? res16[15:8] : res16[7:0];
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= ARM;
            busy     <= 1'b1;
            done     <= 1'b0;
            gsel_q   <= gate_sel;
            gate_cnt <= '0;
            cnt      <= '0;
            ovf_bit  <= 1'b0;
`ifdef OSC_CNT_AVG_EN
            acc      <= '0;
`endif
          end
        end
        // ARM only lets stale synchronizer contents drain; rises are dropped.
        ARM: begin
          if (gate_cnt == GATE_CNT_W'(ARM_CYCLES - 1)) begin
            state    <= GATE;
            gate_cnt <= '0;
          end else begin
            gate_cnt <= gate_cnt + GATE_CNT_W'(1);
          end
        end
        GATE: begin
          gate_cnt <= gate_cnt + GATE_CNT_W'(1);
          cnt      <= cnt_inc;
          ovf_bit  <= ovf_bit | ovf_inc;
`ifdef OSC_CNT_AVG_EN
          if (win_end) begin
            acc <= acc_sum;
            cnt <= '0;
          end
`endif
          // The final cycle's rise is folded straight into the result.
          if (meas_end) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= result_nx;
            ovf    <= ovf_bit | ovf_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_osc_freq_counter.sv
// Self-checking bench for osc_freq_counter: scoreboard of expected results.
module tb_osc_freq_counter;

`ifdef OSC_CNT_AVG_EN
  localparam int NWIN = 4;
`else
  localparam int NWIN = 1;
`endif

  typedef struct {
    int   lo;
    int   hi;
    logic eovf;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       osc_in;
  logic       start;
  logic [2:0] gate_sel;
  logic       byte_sel;
  logic       busy;
  logic       done;
  logic       ovf;
  logic [7:0] read_data;

  int   errors;
  int   checks;
  int   cyc;
  int   osc_half;
  logic last_ovf;
  exp_t exp_q[$];

  osc_freq_counter dut (
    .clk       (clk),
    .rst       (rst),
    .osc_in    (osc_in),
    .start     (start),
    .gate_sel  (gate_sel),
    .byte_sel  (byte_sel),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf),
    .read_data (read_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Oscillator model: toggles every osc_half clk cycles (0 = held low).
  initial begin
    int ph;
    ph = 0;
    osc_in = 1'b0;
    forever begin
      @(negedge clk);
      if (osc_half == 0) begin
        osc_in = 1'b0;
        ph = 0;
      end else begin
        ph++;
        if (ph >= osc_half) begin
          ph = 0;
          osc_in = ~osc_in;
        end
      end
    end
  end

  function automatic int meas_len(input int g);
    return (1 << (10 + g)) * NWIN;
  endfunction

  task automatic pulse_start(input int g, input int lo, input int hi,
                             input logic eovf, output int n);
    exp_t e;
    gate_sel = 3'(g);
    start    = 1'b1;
    n        = cyc;
    e.lo = lo; e.hi = hi; e.eovf = eovf;
    exp_q.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    gate_sel = ~3'(g);
  endtask

  task automatic wait_done(input int max_cyc, output bit ok);
    int k;
    k = 0;
    while (done !== 1'b1 && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    ok = (done === 1'b1);
  endtask

  task automatic read_result(output logic [15:0] r);
    byte_sel = 1'b0;
    @(negedge clk);
    r[7:0] = read_data;
    byte_sel = 1'b1;
    @(negedge clk);
    r[15:8] = read_data;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; byte_sel = 1'b0; gate_sel = 3'd0; osc_half = 0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    checks++; if (read_data !== 8'h00) begin errors++; $display("FAIL reset_read_data: got %h expected 00", read_data); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_idle: got busy=%b done=%b expected 0 0", busy, done); end
    last_ovf = 1'b0;
  endtask

  task automatic test_measure();
    int n; bit ok; exp_t e; logic [7:0] lo_b; logic [15:0] r;
    osc_half = 5;
    pulse_start(0, 102, 103, 1'b0, n);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL meas_busy_arm: got %b expected 1", busy); end
    wait_done(meas_len(0) + 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL meas_done_timeout: got done=%b expected 1", done); end
    checks++; if (cyc - n != 3 + meas_len(0)) begin errors++; $display("FAIL meas_latency: got %0d expected %0d", cyc - n, 3 + meas_len(0)); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL meas_busy_done: got %b expected 0", busy); end
    e = exp_q.pop_front();
    byte_sel = 1'b0;
    @(negedge clk);
    lo_b = read_data;
    byte_sel = 1'b1;
    #1;
    checks++; if (read_data !== lo_b) begin errors++; $display("FAIL meas_byte_sel_latency: got %h expected %h", read_data, lo_b); end
    @(negedge clk);
    r = {read_data, lo_b};
    checks++; if (int'(r) < e.lo || int'(r) > e.hi) begin errors++; $display("FAIL meas_result: got %0d expected %0d..%0d", r, e.lo, e.hi); end
    checks++; if (ovf !== e.eovf) begin errors++; $display("FAIL meas_ovf: got %b expected %b", ovf, e.eovf); end
    last_ovf = e.eovf;
  endtask

  task automatic test_start_ignored();
    int n; bit ok; exp_t e; logic [15:0] r;
    osc_half = 5;
    pulse_start(0, 102, 103, 1'b0, n);
    while (cyc < n + 100) @(negedge clk);
    start = 1'b1; gate_sel = 3'd7;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL ign_still_busy: got busy=%b done=%b expected 1 0", busy, done); end
    wait_done(meas_len(7) + 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ign_done_timeout: got done=%b expected 1", done); end
    checks++; if (cyc - n != 3 + meas_len(0)) begin errors++; $display("FAIL ign_latency: got %0d expected %0d", cyc - n, 3 + meas_len(0)); end
    e = exp_q.pop_front();
    read_result(r);
    checks++; if (int'(r) < e.lo || int'(r) > e.hi) begin errors++; $display("FAIL ign_result: got %0d expected %0d..%0d", r, e.lo, e.hi); end
    last_ovf = e.eovf;
  endtask

  task automatic test_saturation();
    int n; bit ok; exp_t e; logic [15:0] r;
    osc_half = 1;
    pulse_start(7, 65535, 65535, 1'b1, n);
    wait_done(meas_len(7) + 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sat_done_timeout: got done=%b expected 1", done); end
    checks++; if (cyc - n != 3 + meas_len(7)) begin errors++; $display("FAIL sat_latency: got %0d expected %0d", cyc - n, 3 + meas_len(7)); end
    e = exp_q.pop_front();
    read_result(r);
    checks++; if (int'(r) < e.lo || int'(r) > e.hi) begin errors++; $display("FAIL sat_result: got %h expected %h", r, 16'(e.lo)); end
    checks++; if (ovf !== e.eovf) begin errors++; $display("FAIL sat_ovf: got %b expected %b", ovf, e.eovf); end
    last_ovf = e.eovf;
  endtask

  task automatic test_reset_mid();
    int n; bit ok; exp_t e; logic [15:0] r;
    osc_half = 5;
    pulse_start(0, 0, 0, 1'b0, n);
    checks++; if (ovf !== last_ovf) begin errors++; $display("FAIL mid_ovf_held: got %b expected %b", ovf, last_ovf); end
    while (cyc < n + 500) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    byte_sel = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL mid_reset_flags: got busy=%b done=%b ovf=%b expected 0 0 0", busy, done, ovf); end
    checks++; if (read_data !== 8'h00) begin errors++; $display("FAIL mid_reset_read_data: got %h expected 00", read_data); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (read_data !== 8'h00) begin errors++; $display("FAIL mid_result_cleared: got %h expected 00", read_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_idle: got busy=%b expected 0", busy); end
    pulse_start(0, 102, 103, 1'b0, n);
    wait_done(meas_len(0) + 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_done_timeout: got done=%b expected 1", done); end
    checks++; if (cyc - n != 3 + meas_len(0)) begin errors++; $display("FAIL mid_latency: got %0d expected %0d", cyc - n, 3 + meas_len(0)); end
    e = exp_q.pop_front();
    read_result(r);
    checks++; if (int'(r) < e.lo || int'(r) > e.hi) begin errors++; $display("FAIL mid_result: got %0d expected %0d..%0d", r, e.lo, e.hi); end
    checks++; if (ovf !== e.eovf) begin errors++; $display("FAIL mid_ovf: got %b expected %b", ovf, e.eovf); end
    last_ovf = e.eovf;
  endtask

  task automatic test_back_to_back();
    int n; bit ok; exp_t e; logic [15:0] r;
    osc_half = 5;
    gate_sel = 3'd0;
    start = 1'b1;
    n = cyc;
    e.lo = 102; e.hi = 103; e.eovf = 1'b0;
    exp_q.push_back(e);
    exp_q.push_back(e);
    @(negedge clk);
    wait_done(meas_len(0) + 50, ok);
    checks++; if (!ok || cyc - n != 3 + meas_len(0)) begin errors++; $display("FAIL b2b_first_done: got %0d expected %0d", cyc - n, 3 + meas_len(0)); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_restart: got busy=%b done=%b expected 1 0", busy, done); end
    e = exp_q.pop_front();
    read_result(r);
    checks++; if (int'(r) < e.lo || int'(r) > e.hi) begin errors++; $display("FAIL b2b_first_result: got %0d expected %0d..%0d", r, e.lo, e.hi); end
    wait_done(meas_len(0) + 50, ok);
    checks++; if (!ok || cyc - n != 2 * (3 + meas_len(0))) begin errors++; $display("FAIL b2b_second_done: got %0d expected %0d", cyc - n, 2 * (3 + meas_len(0))); end
    start = 1'b0;
    e = exp_q.pop_front();
    read_result(r);
    checks++; if (int'(r) < e.lo || int'(r) > e.hi) begin errors++; $display("FAIL b2b_second_result: got %0d expected %0d..%0d", r, e.lo, e.hi); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done_hold: got %b expected 1", done); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    osc_half = 0;
    rst = 1'b1; start = 1'b0; byte_sel = 1'b0; gate_sel = 3'd0;
    test_reset();
    test_measure();
    test_start_ignored();
`ifndef OSC_CNT_AVG_EN
    test_saturation();
`endif
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
